// File: rtl/sn74169_seq.sv
// sn74169_seq
//   Sequencer for one 4-bit sn74169 synchronous up/down counter.
//   A command preloads a start value, lets the counter run in the chosen
//   direction through a programmed number of terminal-count wraps, and then
//   halts it exactly on a programmed stop value.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for i_start; config captured on the strobe
//   LOAD  | LOADB low for one cycle, counter takes o_a on this edge
//   RUN   | counter enabled until the stop compare is armed and matches
//   FIN   | one-cycle o_done pulse, then back to IDLE
//
// Ports
//   i_clk, i_rst       clock shared with the counter, async active-high reset
//   i_start            command strobe (honoured only in IDLE)
//   i_cfg_start/stop   preload value / final halt value
//   i_cfg_dir          1 = count up, 0 = count down
//   i_cfg_reps         RCOB wraps required before the stop compare is armed
//   i_hold, i_abort    pause counting / cancel the command
//   i_q, i_rcob        counter outputs (RCOB active low)
//   o_a, o_loadb       preload data and active-low load to the counter
//   o_enpb, o_entb     active-low count enables (combinational)
//   o_u_db             up/down select to the counter
//   o_busy, o_done     busy in LOAD/RUN, one-cycle completion pulse
//   o_pass_cnt         wraps seen in the current command
module sn74169_seq #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_cfg_start,
  input  logic [WIDTH-1:0] i_cfg_stop,
  input  logic             i_cfg_dir,
  input  logic [REP_W-1:0] i_cfg_reps,
  input  logic             i_hold,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_rcob,
  output logic [WIDTH-1:0] o_a,
  output logic             o_loadb,
  output logic             o_enpb,
  output logic             o_entb,
  output logic             o_u_db,
  output logic             o_busy,
  output logic             o_done,
  output logic [REP_W-1:0] o_pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_stop;
  logic [REP_W-1:0] r_reps;

  logic             w_capture;
  logic             w_stop_hit;
  logic             w_run_en;
  logic             w_wrap;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_stop_nxt;
  logic [REP_W-1:0] w_reps_nxt;
  logic [REP_W-1:0] w_pass_nxt;
  logic             w_u_db_nxt;
  logic             w_loadb_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  // The start value and direction live directly in o_a / o_u_db: both must
  // hold their last command value after FIN anyway.
  assign w_capture  = (r_state == S_IDLE) && i_start && !i_abort;

  // Stop compare is only armed once the required number of wraps is seen,
  // so start == stop with reps > 0 still runs full laps first.
  assign w_stop_hit = (o_pass_cnt == r_reps) && (i_q == r_stop);

  // Abort gates the enables in its own cycle so the counter freezes on the
  // value it shows when ABORT is raised.
  assign w_run_en   = (r_state == S_RUN) && !i_hold && !i_abort && !w_stop_hit;
  assign w_wrap     = w_run_en && !i_rcob;

  // State register plus the registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_stop     <= '0;
      r_reps     <= '0;
      o_a        <= '0;
      o_u_db     <= 1'b1;
      o_loadb    <= 1'b1;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_pass_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_stop     <= w_stop_nxt;
      r_reps     <= w_reps_nxt;
      o_a        <= w_a_nxt;
      o_u_db     <= w_u_db_nxt;
      o_loadb    <= w_loadb_nxt;
      o_busy     <= w_busy_nxt;
      o_done     <= w_done_nxt;
      o_pass_cnt <= w_pass_nxt;
    end
  end

  // Next-state logic; abort wins over everything else.
  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_state_nxt = S_LOAD;
        S_LOAD:  w_state_nxt = S_RUN;
        S_RUN:   if (w_stop_hit) w_state_nxt = S_FIN;
        S_FIN:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: live enables, plus next values of the registered outputs
  // derived from the next state so they line up with the state they describe.
  always_comb begin
    o_enpb      = ~w_run_en;
    o_entb      = ~w_run_en;
    w_loadb_nxt = (w_state_nxt != S_LOAD);
    w_busy_nxt  = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN);
    w_done_nxt  = (w_state_nxt == S_FIN);

    w_a_nxt     = o_a;
    w_u_db_nxt  = o_u_db;
    w_stop_nxt  = r_stop;
    w_reps_nxt  = r_reps;
    w_pass_nxt  = o_pass_cnt;

    if (w_capture) begin
      w_a_nxt    = i_cfg_start;
      w_u_db_nxt = i_cfg_dir;
      w_stop_nxt = i_cfg_stop;
      w_reps_nxt = i_cfg_reps;
      w_pass_nxt = '0;
    end else if (w_wrap && (o_pass_cnt != '1)) begin
      w_pass_nxt = o_pass_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_sn74169_seq.sv
module tb_sn74169_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] cfg_start = 4'd0;
  logic [3:0] cfg_stop = 4'd0;
  logic       cfg_dir = 1'b1;
  logic [3:0] cfg_reps = 4'd0;
  logic       hold = 1'b0;
  logic       abort_c = 1'b0;
  logic [3:0] q_cnt = 4'd0;
  logic       rcob;
  logic [3:0] a;
  logic       loadb, enpb, entb, u_db, busy, done;
  logic [3:0] pass_cnt;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sn74169_seq #(.WIDTH(4), .REP_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_cfg_start(cfg_start),
    .i_cfg_stop (cfg_stop),
    .i_cfg_dir  (cfg_dir),
    .i_cfg_reps (cfg_reps),
    .i_hold     (hold),
    .i_abort    (abort_c),
    .i_q        (q_cnt),
    .i_rcob     (rcob),
    .o_a        (a),
    .o_loadb    (loadb),
    .o_enpb     (enpb),
    .o_entb     (entb),
    .o_u_db     (u_db),
    .o_busy     (busy),
    .o_done     (done),
    .o_pass_cnt (pass_cnt)
  );

  // Behavioural sn74169: synchronous load, count when both enables low.
  always @(posedge clk) begin
    if (!loadb) q_cnt <= a;
    else if (!enpb && !entb) q_cnt <= u_db ? q_cnt + 4'd1 : q_cnt - 4'd1;
  end
  assign rcob = !(!entb && (u_db ? (q_cnt == 4'hF) : (q_cnt == 4'h0)));

  typedef struct {
    logic [3:0] st;
    logic [3:0] sp;
    logic       dir;
    logic [3:0] reps;
    int         edges;
    int         pass;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Wraps unavoidable on the direct path from st to sp.
  function automatic int wraps0(input int st, input int sp, input bit dir);
    if (dir) return (sp < st) ? 1 : 0;
    else     return (sp > st) ? 1 : 0;
  endfunction

  // Count edges: direct distance plus one full lap per extra required wrap.
  function automatic int ref_edges(input int st, input int sp, input bit dir, input int reps);
    int d;
    d = dir ? ((sp - st + 16) % 16) : ((st - sp + 16) % 16);
    return d + 16 * (reps - wraps0(st, sp, dir));
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_a"}, a, 0);
    check({tag, "_loadb"}, loadb, 1);
    check({tag, "_enpb"}, enpb, 1);
    check({tag, "_entb"}, entb, 1);
    check({tag, "_u_db"}, u_db, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass_cnt, 0);
  endtask

  // Issues one command and follows it to DONE. lat = cycles from the START
  // cycle to the DONE cycle. Returns at #1 after the negedge of the DONE cycle.
  task automatic run_cmd(input logic [3:0] st, input logic [3:0] sp, input logic dir,
                         input logic [3:0] reps, input int hold_at, input int hold_len,
                         input bit mid_start, output int edges, output int lat,
                         output int held_en, output bit to);
    @(negedge clk);
    cfg_start = st; cfg_stop = sp; cfg_dir = dir; cfg_reps = reps;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("load_loadb", loadb, 0);
    check("load_a", a, st);
    check("load_u_db", u_db, dir);
    lat = 1; edges = 0; held_en = 0;
    while (lat < 600) begin
      hold = (lat >= hold_at) && (lat < hold_at + hold_len);
      start = mid_start && (lat == 3);
      if (start) begin
        cfg_start = 4'd0; cfg_stop = 4'd12; cfg_dir = !dir; cfg_reps = 4'd3;
      end
      #1;
      if (done) break;
      if (!enpb && !entb) edges++;
      if (hold && !(enpb && entb)) held_en++;
      @(negedge clk);
      lat++;
    end
    hold = 1'b0;
    start = 1'b0;
    to = !done;
  endtask

  initial begin
    int e, l, h, k, n, w0, ha, hl;
    bit to, seen;
    logic [3:0] st, sp, rp;
    logic dr;

    vecs[0] = '{4'd3,  4'd7,  1'b1, 4'd0, 4,  0};
    vecs[1] = '{4'd14, 4'd2,  1'b1, 4'd1, 4,  1};
    vecs[2] = '{4'd2,  4'd13, 1'b0, 4'd2, 21, 2};
    vecs[3] = '{4'd9,  4'd9,  1'b1, 4'd0, 0,  0};
    vecs[4] = '{4'd9,  4'd9,  1'b0, 4'd1, 16, 1};
    vecs[5] = '{4'd5,  4'd0,  1'b0, 4'd0, 5,  0};
    vecs[6] = '{4'd15, 4'd15, 1'b1, 4'd1, 16, 1};
    vecs[7] = '{4'd0,  4'd15, 1'b1, 4'd0, 15, 0};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("rst0");
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_cmd(vecs[i].st, vecs[i].sp, vecs[i].dir, vecs[i].reps, 0, 0, 1'b0, e, l, h, to);
      check("vec_timeout", to, 0);
      check("vec_edges", e, vecs[i].edges);
      check("vec_latency", l, vecs[i].edges + 3);
      check("vec_q_done", q_cnt, vecs[i].sp);
      check("vec_pass", pass_cnt, vecs[i].pass);
      check("vec_busy_done", busy, 0);
      @(negedge clk);
      #1;
      check("vec_done_1cyc", done, 0);
      check("vec_q_hold", q_cnt, vecs[i].sp);
      check("vec_loadb_idle", loadb, 1);
    end

    // HOLD for 3 cycles mid-run delays DONE by exactly 3 cycles.
    run_cmd(4'd3, 4'd7, 1'b1, 4'd0, 3, 3, 1'b0, e, l, h, to);
    check("hold_timeout", to, 0);
    check("hold_edges", e, 4);
    check("hold_latency", l, 10);
    check("hold_en_low", h, 0);
    check("hold_q", q_cnt, 7);

    // START during FIN is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("fin_start_busy", busy, 0);
    check("fin_start_loadb", loadb, 1);
    @(negedge clk);
    #1;
    check("fin_start_busy2", busy, 0);

    // START during RUN is ignored; original stop honoured.
    run_cmd(4'd3, 4'd7, 1'b1, 4'd0, 0, 0, 1'b1, e, l, h, to);
    check("midstart_timeout", to, 0);
    check("midstart_edges", e, 4);
    check("midstart_latency", l, 7);
    check("midstart_q", q_cnt, 7);
    check("midstart_u_db", u_db, 1);

    // ABORT when Q = 5.
    @(negedge clk);
    cfg_start = 4'd3; cfg_stop = 4'd7; cfg_dir = 1'b1; cfg_reps = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (q_cnt != 4'd5 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_reach_q5", int'(k < 20), 1);
    abort_c = 1'b1;
    #1;
    check("abort_en_same_cycle", enpb, 1);
    @(negedge clk);
    abort_c = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_entb", entb, 1);
    check("abort_loadb", loadb, 1);
    check("abort_done", done, 0);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      seen |= done;
    end
    check("abort_no_done", seen, 0);
    check("abort_q_hold", q_cnt, 5);

    // Asynchronous reset mid-RUN, between clock edges.
    @(negedge clk);
    cfg_start = 4'd2; cfg_stop = 4'd13; cfg_dir = 1'b0; cfg_reps = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (pass_cnt != 4'd1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_pass1", int'(k < 40), 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    rst = 1'b0;

    // Randomized commands against the arithmetic reference.
    for (int it = 0; it < 30; it++) begin
      st = 4'($urandom_range(0, 15));
      sp = 4'($urandom_range(0, 15));
      dr = 1'($urandom_range(0, 1));
      rp = 4'($urandom_range(0, 2));
      w0 = wraps0(int'(st), int'(sp), dr);
      if (int'(rp) < w0) rp = 4'(w0);
      n = ref_edges(int'(st), int'(sp), dr, int'(rp));
      ha = 0; hl = 0;
      if (n > 0) begin
        ha = $urandom_range(2, n + 1);
        hl = $urandom_range(0, 3);
      end
      run_cmd(st, sp, dr, rp, ha, hl, 1'b0, e, l, h, to);
      check("rnd_timeout", to, 0);
      check("rnd_edges", e, n);
      check("rnd_latency", l, n + 3 + hl);
      check("rnd_q", q_cnt, sp);
      check("rnd_pass", pass_cnt, rp);
      check("rnd_hold_en", h, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
